// File: rtl/multi_dir_traffic_controller_if.sv
// Signal bundle between sensor conditioning / lamp drivers and the traffic controller.
// master drives time base, sensors and flash request; slave is the controller.
interface multi_dir_traffic_controller_if #(
    parameter int unsigned N_DIRS = 4,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned DIR_W = $clog2(N_DIRS);

    logic              tick;
    logic [N_DIRS-1:0] sense;
    logic              flash_en;
    logic [N_DIRS-1:0] red;
    logic [N_DIRS-1:0] yellow;
    logic [N_DIRS-1:0] green;
    logic [DIR_W-1:0]  cur_dir;
    logic [1:0]        state;
    logic [CNT_W-1:0]  timer;

    modport master (
        output tick, sense, flash_en,
        input  red, yellow, green, cur_dir, state, timer
    );

    modport slave (
        input  tick, sense, flash_en,
        output red, yellow, green, cur_dir, state, timer
    );
endinterface

// File: rtl/multi_dir_traffic_controller.sv
// N-approach round-robin traffic-light controller with demand latching, min/max green,
// gap-out extension, all-red clearance and maintenance flash. All timing is in ticks.
module multi_dir_traffic_controller #(
    parameter int unsigned N_DIRS      = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_GREEN_MIN = 10,
    parameter int unsigned T_GREEN_MAX = 60,
    parameter int unsigned T_YELLOW    = 5,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned REST_DIR    = 0
) (
    input logic                        clk,
    input logic                        reset,
    multi_dir_traffic_controller_if.slave bus
);
    localparam int unsigned DIR_W = $clog2(N_DIRS);

    localparam logic [1:0] StGreen  = 2'd0;
    localparam logic [1:0] StYellow = 2'd1;
    localparam logic [1:0] StAllRed = 2'd2;
    localparam logic [1:0] StFlash  = 2'd3;

    localparam logic [CNT_W:0]   GMIN     = (CNT_W+1)'(T_GREEN_MIN);
    localparam logic [CNT_W:0]   GMAX     = (CNT_W+1)'(T_GREEN_MAX);
    localparam logic [CNT_W:0]   TYEL     = (CNT_W+1)'(T_YELLOW);
    localparam logic [CNT_W:0]   TAR      = (CNT_W+1)'(T_ALLRED);
    localparam logic [CNT_W-1:0] TIMER_MX = '1;
    localparam logic [DIR_W-1:0] REST     = DIR_W'(REST_DIR);

    logic [1:0]        state_q, state_d;
    logic [DIR_W-1:0]  cur_q, cur_d;
    logic [DIR_W-1:0]  nxt_q, nxt_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [N_DIRS-1:0] req_q, req_d;
    logic              blink_q, blink_d;

    logic [CNT_W:0]    t;
    logic [N_DIRS-1:0] cur_mask;
    logic              other_req;
    logic [DIR_W-1:0]  scan_dir;
    logic              scan_found;
    int unsigned       scan_idx;

    // One extra bit so the timer+1 compare cannot wrap at saturation.
    assign t         = {1'b0, timer_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cur_mask  = {{(N_DIRS-1){1'b0}}, 1'b1} << cur_q;
    assign other_req = |(req_q & ~cur_mask);

    // First pending approach after cur_dir, wrapping around.
    always_comb begin
        scan_dir   = cur_q;
        scan_found = 1'b0;
        scan_idx   = 0;
        for (int unsigned k = 1; k < N_DIRS; k++) begin
            scan_idx = (32'(cur_q) + k) % N_DIRS;
            if (!scan_found && req_q[scan_idx]) begin
                scan_found = 1'b1;
                scan_dir   = DIR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        blink_d = blink_q;
        req_d   = req_q | (bus.sense & ~((state_q == StGreen) ? cur_mask : '0));

        if (bus.flash_en) begin
            state_d = StFlash;
            if (state_q != StFlash) begin
                blink_d = 1'b1;
            end else if (bus.tick) begin
                blink_d = ~blink_q;
            end
        end else begin
            case (state_q)
                StFlash: begin
                    state_d = StAllRed;
                    nxt_d   = REST;
                end
                StGreen: begin
                    if (bus.tick && other_req && t >= GMIN &&
                        (!bus.sense[cur_q] || t >= GMAX)) begin
                        state_d = StYellow;
                        nxt_d   = scan_dir;
                    end
                end
                StYellow: begin
                    if (bus.tick && t == TYEL) state_d = StAllRed;
                end
                default: begin
                    if (bus.tick && t == TAR) begin
                        state_d       = StGreen;
                        cur_d         = nxt_q;
                        req_d[nxt_q]  = 1'b0;
                    end
                end
            endcase
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (bus.tick && timer_q != TIMER_MX) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StAllRed;
            cur_q   <= REST;
            nxt_q   <= REST;
            timer_q <= '0;
            req_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        bus.red    = '0;
        bus.yellow = '0;
        bus.green  = '0;
        case (state_q)
            StGreen: begin
                bus.green = cur_mask;
                bus.red   = ~cur_mask;
            end
            StYellow: begin
                bus.yellow = cur_mask;
                bus.red    = ~cur_mask;
            end
            StFlash:  bus.yellow = {N_DIRS{blink_q}};
            default:  bus.red    = '1;
        endcase
    end

    assign bus.cur_dir = cur_q;
    assign bus.state   = state_q;
    assign bus.timer   = timer_q;
endmodule

// File: tb/tb_multi_dir_traffic_controller.sv
// Randomized bench for multi_dir_traffic_controller against a phase-level reference model.
module tb_multi_dir_traffic_controller;
    localparam int N    = 4;
    localparam int TMIN = 3;
    localparam int TMAX = 6;
    localparam int TY   = 2;
    localparam int TAR  = 1;
    localparam int REST = 0;
    localparam int SAT  = 255;

    localparam int PH_GREEN = 0;
    localparam int PH_YEL   = 1;
    localparam int PH_AR    = 2;
    localparam int PH_FLASH = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_dir_traffic_controller_if #(.N_DIRS(N), .CNT_W(8)) bus ();

    multi_dir_traffic_controller #(
        .N_DIRS(N), .CNT_W(8), .T_GREEN_MIN(TMIN), .T_GREEN_MAX(TMAX),
        .T_YELLOW(TY), .T_ALLRED(TAR), .REST_DIR(REST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    int m_phase, m_dir, m_nxt, m_elapsed;
    bit m_blink;
    bit m_req[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bump(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    function automatic void model_step(input bit r, input bit tk, input bit [N-1:0] s,
                                       input bit f);
        bit nreq[N];
        bit others;
        bit found;
        int n;
        if (r) begin
            m_phase = PH_AR; m_dir = REST; m_nxt = REST; m_elapsed = 0; m_blink = 0;
            foreach (m_req[i]) m_req[i] = 0;
            return;
        end
        foreach (nreq[i]) nreq[i] = m_req[i] | (s[i] && !(m_phase == PH_GREEN && i == m_dir));
        if (f) begin
            if (m_phase != PH_FLASH) begin
                m_phase = PH_FLASH; m_elapsed = 0; m_blink = 1;
            end else if (tk) begin
                m_blink = !m_blink; m_elapsed = bump(m_elapsed);
            end
        end else if (m_phase == PH_FLASH) begin
            m_phase = PH_AR; m_nxt = REST; m_elapsed = 0;
        end else if (tk) begin
            n = m_elapsed + 1;
            if (m_phase == PH_GREEN) begin
                others = 0;
                for (int i = 0; i < N; i++) if (i != m_dir && m_req[i]) others = 1;
                if (others && n >= TMIN && (!s[m_dir] || n >= TMAX)) begin
                    found = 0;
                    for (int k = 1; k < N; k++) begin
                        if (!found && m_req[(m_dir + k) % N]) begin
                            found = 1; m_nxt = (m_dir + k) % N;
                        end
                    end
                    m_phase = PH_YEL; m_elapsed = 0;
                end else m_elapsed = bump(m_elapsed);
            end else if (m_phase == PH_YEL) begin
                if (n == TY) begin m_phase = PH_AR; m_elapsed = 0; end
                else m_elapsed = bump(m_elapsed);
            end else begin
                if (n == TAR) begin
                    m_phase = PH_GREEN; m_dir = m_nxt; nreq[m_dir] = 0; m_elapsed = 0;
                end else m_elapsed = bump(m_elapsed);
            end
        end
        m_req = nreq;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] er, ey, eg;
        er = '0; ey = '0; eg = '0;
        for (int i = 0; i < N; i++) begin
            if (m_phase == PH_FLASH) ey[i] = m_blink;
            else if (m_phase == PH_GREEN && i == m_dir) eg[i] = 1'b1;
            else if (m_phase == PH_YEL && i == m_dir) ey[i] = 1'b1;
            else er[i] = 1'b1;
        end
        check("state", 32'(bus.state), 32'(m_phase));
        check("red", 32'(bus.red), 32'(er));
        check("yellow", 32'(bus.yellow), 32'(ey));
        check("green", 32'(bus.green), 32'(eg));
        check("cur_dir", 32'(bus.cur_dir), 32'(m_dir));
        check("timer", 32'(bus.timer), 32'(m_elapsed));
    endtask

    task automatic cycle(input bit r, input bit tk, input bit [N-1:0] s, input bit f);
        reset        = r;
        bus.tick     = tk;
        bus.sense    = s;
        bus.flash_en = f;
        model_step(r, tk, s, f);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit [N-1:0] s;
        bit f;
        bit tk;
        // Power-up reset, then idle rest in green long enough to saturate the timer.
        cycle(1, 1, '0, 0);
        cycle(1, 1, '0, 0);
        for (int i = 0; i < 300; i++) cycle(0, 1, '0, 0);

        // Demand on dir2 from a fresh green on dir0.
        cycle(1, 1, '0, 0);
        cycle(0, 1, '0, 0);
        cycle(0, 1, 4'b0100, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, '0, 0);

        // Gap-out: sense on the green approach held, then dropped early.
        cycle(1, 1, '0, 0);
        cycle(0, 1, '0, 0);
        cycle(0, 1, 4'b0011, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 4'b0001, 0);
        cycle(1, 1, '0, 0);
        cycle(0, 1, '0, 0);
        cycle(0, 1, 4'b0011, 0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 4'b0001, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, '0, 0);

        // Flash mid-green with pending demand, then exit.
        cycle(0, 1, 4'b1010, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, '0, 1);
        for (int i = 0; i < 30; i++) cycle(0, 1, '0, 0);

        // Randomized traffic with occasional flash, tick gaps and resets.
        s = '0; f = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(2, 0) == 0)
                for (int b = 0; b < N; b++) s[b] = ($urandom_range(5, 0) == 0);
            if ($urandom_range(80, 0) == 0) f = !f;
            tk = ($urandom_range(4, 0) != 0);
            cycle(($urandom_range(600, 0) == 0), tk, s, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
